// File: rtl/iomem_xbar_pkg.sv
// Shared types and constants for the iomem crossbar: sequencer states,
// status register layout, default error word and the index-width helper.
package iomem_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int STAT_DECERR_BIT = 0;
    localparam int STAT_TMO_BIT    = 1;
    localparam int STAT_IDX_LSB    = 8;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iomem_xbar_if.sv
// Bundle of the picorv32 iomem side and the per-slave channel side.
// slave = crossbar view; master = environment driving the CPU bus and peripherals.
interface iomem_xbar_if #(
    parameter int NUM_SLAVES = 4
);
    logic                    m_valid;
    logic [31:0]             m_addr;
    logic [31:0]             m_wdata;
    logic [3:0]              m_wstrb;
    logic                    m_ready;
    logic [31:0]             m_rdata;
    logic [NUM_SLAVES-1:0]   s_sel;
    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [3:0]              s_wstrb;
    logic [NUM_SLAVES-1:0]   s_ready;
    logic [NUM_SLAVES*32-1:0] s_rdata;
    logic                    err_irq;

    modport slave (
        input  m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        output m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb, err_irq
    );

    modport master (
        output m_valid, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
        input  m_ready, m_rdata, s_sel, s_addr, s_wdata, s_wstrb, err_irq
    );
endinterface

// File: rtl/iomem_xbar_wdog.sv
// WAIT-state watchdog: counts cycles spent waiting on a slave and flags the
// last permitted cycle. Only instantiated when IOMEM_XBAR_TIMEOUT_EN is defined.
module iomem_xbar_wdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // count holds the number of WAIT cycles already elapsed, so this is the last one
    assign expired_o = en_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/iomem_xbar.sv
// Registered iomem decoder: IDLE/WAIT/RESP sequencer, one-hot slave select,
// built-in status register. Optional watchdog under IOMEM_XBAR_TIMEOUT_EN.
module iomem_xbar
    import iomem_xbar_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE     = {4{32'h0}},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK     = {4{32'hFF00_0000}},
    parameter logic [31:0]              STATUS_ADDR    = 32'h0300_0004,
    parameter int                       TIMEOUT_CYCLES = 255,
    parameter logic [31:0]              ERR_DATA       = ERR_DATA_DEFAULT
) (
    input  logic         clk,
    input  logic         resetn,
    iomem_xbar_if.slave  bus
);
    localparam int IDX_W = idx_w(NUM_SLAVES);

    state_e                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    decerr_q, decerr_d;
    logic                    tmo_q, tmo_d;
    logic [3:0]              tmo_idx_q, tmo_idx_d;

    logic                    hit;
    logic                    status_hit;
    logic [IDX_W-1:0]        dec_idx;
    logic [31:0]             status_word;
    logic                    wd_expired;

`ifdef IOMEM_XBAR_TIMEOUT_EN
    iomem_xbar_wdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (resetn),
        .clr_i     (state_q != WAIT),
        .en_i      (state_q == WAIT),
        .expired_o (wd_expired)
    );
`else
    // never true for a legal TIMEOUT_CYCLES, so WAIT lasts until the slave answers
    assign wd_expired = (TIMEOUT_CYCLES == 0);
`endif

    // descending scan so the lowest matching slot is the one left standing
    always_comb begin
        hit        = 1'b0;
        dec_idx    = '0;
        status_hit = (bus.m_addr == STATUS_ADDR);
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus.m_addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
                hit     = 1'b1;
                dec_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        status_word                                 = '0;
        status_word[STAT_DECERR_BIT]                = decerr_q;
        status_word[STAT_TMO_BIT]                   = tmo_q;
        status_word[STAT_IDX_LSB +: 4]              = tmo_idx_q;
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        decerr_d  = decerr_q;
        tmo_d     = tmo_q;
        tmo_idx_d = tmo_idx_q;
        case (state_q)
            IDLE: begin
                if (bus.m_valid) begin
                    addr_d  = bus.m_addr;
                    wdata_d = bus.m_wdata;
                    wstrb_d = bus.m_wstrb;
                    if (status_hit) begin
                        rdata_d = status_word;
                        state_d = RESP;
                        if (bus.m_wstrb[0]) begin
                            if (bus.m_wdata[STAT_DECERR_BIT]) decerr_d = 1'b0;
                            if (bus.m_wdata[STAT_TMO_BIT])    tmo_d    = 1'b0;
                        end
                    end else if (!hit) begin
                        rdata_d  = ERR_DATA;
                        decerr_d = 1'b1;
                        state_d  = RESP;
                    end else begin
                        idx_d          = dec_idx;
                        sel_d          = '0;
                        sel_d[dec_idx] = 1'b1;
                        state_d        = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.s_ready[idx_q]) begin
                    rdata_d = bus.s_rdata[{idx_q, 5'd0} +: 32];
                    sel_d   = '0;
                    state_d = RESP;
                end else if (wd_expired) begin
                    rdata_d   = ERR_DATA;
                    tmo_d     = 1'b1;
                    tmo_idx_d = 4'(idx_q);
                    sel_d     = '0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            decerr_q  <= 1'b0;
            tmo_q     <= 1'b0;
            tmo_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            decerr_q  <= decerr_d;
            tmo_q     <= tmo_d;
            tmo_idx_q <= tmo_idx_d;
        end
    end

    assign bus.m_ready = (state_q == RESP);
    assign bus.m_rdata = rdata_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.s_wstrb = wstrb_q;
    assign bus.err_irq = decerr_q | tmo_q;

endmodule
